// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch unit (i_*) and the load/store unit (d_*).
// One transaction outstanding at a time; a starvation counter bounds data-side priority.
module mem_port_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned BUS_WID    = 128,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned LANES      = BUS_WID / XLEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req,
    input  logic [XLEN-1:0]      i_addr,
    input  logic                 i_kill,
    output logic                 i_gnt,
    output logic                 i_resp,
    output logic [BUS_WID-1:0]   i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [XLEN-1:0]      d_addr,
    input  logic [XLEN-1:0]      d_wdata,
    input  logic [XLEN/8-1:0]    d_be,
    output logic                 d_gnt,
    output logic                 d_resp,
    output logic [XLEN-1:0]      d_rdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [XLEN-1:0]      mem_addr,
    output logic [BUS_WID-1:0]   mem_wdata,
    output logic [BUS_WID/8-1:0] mem_be,
    input  logic [BUS_WID-1:0]   mem_rdata,
    input  logic                 mem_resp
);

    localparam int unsigned XB     = XLEN / 8;
    localparam int unsigned OFF_W  = (XB > 1) ? $clog2(XB) : 1;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned CNT_W  = $clog2(STARVE_MAX + 1);
    localparam int unsigned BE_W   = BUS_WID / 8;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_kill_pend;
    logic [CNT_W-1:0]   r_starve_cnt;
    logic [LANE_W-1:0]  r_lane_q;
    logic [LANE_W-1:0]  w_d_lane;
    logic [XLEN-1:0]    w_lane_data;
    logic               w_free;

    // Lane index of the data address within a bus line
    generate
        if (LANES > 1) begin : g_lanes
            assign w_d_lane = d_addr[OFF_W +: LANE_W];
            always_comb begin
                w_lane_data = '0;
                for (int unsigned l = 0; l < LANES; l++) begin
                    if (r_lane_q == LANE_W'(l)) w_lane_data = mem_rdata[l*XLEN +: XLEN];
                end
            end
        end else begin : g_one_lane
            assign w_d_lane    = '0;
            assign w_lane_data = '0;
        end
    endgenerate

    assign i_rdata = rst ? '0 : mem_rdata;
    assign d_rdata = rst ? '0 : w_lane_data;

    // Grant, bus mux, responses and next state
    always_comb begin
        w_state_nxt = r_state;
        w_free      = (r_state == IDLE) || mem_resp;
        i_gnt       = 1'b0;
        d_gnt       = 1'b0;
        i_resp      = 1'b0;
        d_resp      = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_be      = '0;
        if (!rst) begin
            if (w_free) begin
                if (i_req && d_req) begin
                    if (r_starve_cnt == CNT_W'(STARVE_MAX)) i_gnt = 1'b1;
                    else                                    d_gnt = 1'b1;
                end else if (i_req) begin
                    i_gnt = 1'b1;
                end else if (d_req) begin
                    d_gnt = 1'b1;
                end
            end
            i_resp  = (r_state == BUSY_I) && mem_resp && !r_kill_pend && !i_kill;
            d_resp  = (r_state == BUSY_D) && mem_resp;
            mem_req = i_gnt || d_gnt;
            if (d_gnt) begin
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = {LANES{d_wdata}};
                mem_be    = d_we ? BE_W'(BE_W'(d_be) << (XB * 32'(w_d_lane))) : '1;
            end else if (i_gnt) begin
                mem_addr  = i_addr;
                mem_be    = '1;
            end
            if (i_gnt)         w_state_nxt = BUSY_I;
            else if (d_gnt)    w_state_nxt = BUSY_D;
            else if (mem_resp) w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Kill tracking, starvation count and data lane capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kill_pend  <= 1'b0;
            r_starve_cnt <= '0;
            r_lane_q     <= '0;
        end else begin
            if (r_state != BUSY_I || mem_resp) r_kill_pend <= 1'b0;
            else if (i_kill)                   r_kill_pend <= 1'b1;

            if (!i_req || i_gnt)
                r_starve_cnt <= '0;
            else if (d_gnt && r_starve_cnt != CNT_W'(STARVE_MAX))
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);

            if (d_gnt) r_lane_q <= w_d_lane;
        end
    end

endmodule
